// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared widths, counter constants, counter helpers and the
//               entry view type for the set-associative branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    // Widest slot field carried in the entry view (FETCH_W up to 256).
    localparam int SLOT_W_MAX = 8;

    // 2-bit confidence counter encoding; predict taken at CTR_WEAK_T or above.
    localparam logic [1:0] CTR_MIN    = 2'd0;
    localparam logic [1:0] CTR_WEAK_T = 2'd2;
    localparam logic [1:0] CTR_MAX    = 2'd3;

    // Number of PC bits selecting the instruction slot inside a fetch group.
    function automatic int off_w(input int fetch_w);
        return $clog2(fetch_w);
    endfunction

    // Tag width left over once byte offset, slot and set index are removed.
    function automatic int tag_w(input int idx_bits, input int fetch_w);
        return 32 - idx_bits - off_w(fetch_w) - 2;
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
    endfunction

    // Read-side view of one way; narrower fields are zero-extended into it.
    typedef struct packed {
        logic                  vld;
        logic [31:0]           tag;
        logic [SLOT_W_MAX-1:0] slot;
        logic [31:0]           target;
        logic [1:0]            ctr;
    } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/btb_plru.sv
`default_nettype none
// ============================================================================
// Module      : btb_plru
// Description : Per-set tree pseudo-LRU. Each set holds WAYS-1 node bits in
//               heap order; a node bit of 1 points the victim walk right.
//               Two touch ports; the update port wins on a shared set.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_plru #(
    parameter int WAYS = 2,
    parameter int SETS = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     lk_touch,
    input  logic [$clog2(SETS)-1:0]  lk_set,
    input  logic [$clog2(WAYS)-1:0]  lk_way,
    input  logic                     up_touch,
    input  logic [$clog2(SETS)-1:0]  up_set,
    input  logic [$clog2(WAYS)-1:0]  up_way,
    input  logic [$clog2(SETS)-1:0]  vic_set,
    output logic [$clog2(WAYS)-1:0]  vic_way
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] state_q [SETS];

    // Walk root to leaf, pointing every node on the path away from the way.
    function automatic logic [NODES-1:0] touch_bits(input logic [NODES-1:0] st,
                                                    input logic [WAY_W-1:0] way);
        logic [NODES-1:0] r;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] path;
        logic             dir;
        r    = st;
        node = '0;
        path = way;
        for (int l = 0; l < WAY_W; l++) begin
            dir     = path[WAY_W-1];
            r[node] = ~dir;
            node    = (node << 1) + WAY_W'(1) + WAY_W'(dir);
            path    = path << 1;
        end
        return r;
    endfunction

    // Follow the node bits from the root to the least recently used leaf.
    function automatic logic [WAY_W-1:0] victim_of(input logic [NODES-1:0] st);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] v;
        logic             dir;
        node = '0;
        v    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            dir  = st[node];
            v    = (v << 1) | WAY_W'(dir);
            node = (node << 1) + WAY_W'(1) + WAY_W'(dir);
        end
        return v;
    endfunction

    // Tree state update: reset/flush clear, otherwise apply touches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '{default: '0};
        end else if (flush) begin
            state_q <= '{default: '0};
        end else begin
            if (lk_touch && !(up_touch && (up_set == lk_set))) begin
                state_q[lk_set] <= touch_bits(state_q[lk_set], lk_way);
            end
            if (up_touch) begin
                state_q[up_set] <= touch_bits(state_q[up_set], up_way);
            end
        end
    end

    assign vic_way = victim_of(state_q[vic_set]);

endmodule
`default_nettype wire

// File: rtl/btb_sa.sv
`default_nettype none
// ============================================================================
// Module      : btb_sa
// Description : Set-associative branch target buffer with per-slot fetch
//               valids, same-cycle training bypass, 2-bit confidence counters
//               and tree-PLRU replacement. Lookup is combinational; the next
//               fetch address is also offered registered.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_sa
    import btb_pkg::*;
#(
    parameter int FETCH_W  = 4,
    parameter int IDX_BITS = 7,
    parameter int WAYS     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc,
    input  logic               stage1_hold,
    input  logic               update_en,
    input  logic [31:0]        update_pc,
    input  logic [31:0]        update_target,
    input  logic               update_taken,
    input  logic               flush,
    output logic               btb_hit,
    output logic [31:0]        pc_target,
    output logic [31:0]        pc_target_stage1,
    output logic [FETCH_W-1:0] inst_vld
);

    localparam int          OFF         = off_w(FETCH_W);
    localparam int          TAG_W       = tag_w(IDX_BITS, FETCH_W);
    localparam int          SETS        = 1 << IDX_BITS;
    localparam int          WAY_W       = $clog2(WAYS);
    localparam logic [31:0] ALIGN_MASK  = ~((32'd1 << (OFF + 2)) - 32'd1);
    localparam logic [31:0] FETCH_BYTES = 32'(4 * FETCH_W);

    // Storage: valid and counter are reset; tag/slot/target are not.
    logic [WAYS-1:0]     vld_q      [SETS];
    logic [1:0]          ctr_q      [WAYS][SETS];
    logic [TAG_W-1:0]    tag_mem    [WAYS][SETS];
    logic [OFF-1:0]      slot_mem   [WAYS][SETS];
    logic [31:0]         target_mem [WAYS][SETS];

    // Address fields of the lookup and the training branch.
    logic [OFF-1:0]      lk_slot;
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [OFF-1:0]      up_slot;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]    up_tag;

    assign lk_slot = pc[OFF+1:2];
    assign lk_idx  = pc[IDX_BITS+OFF+1:OFF+2];
    assign lk_tag  = pc[31:IDX_BITS+OFF+2];
    assign up_slot = update_pc[OFF+1:2];
    assign up_idx  = update_pc[IDX_BITS+OFF+1:OFF+2];
    assign up_tag  = update_pc[31:IDX_BITS+OFF+2];

    // Instruction-alignment bits of the training PC carry no information.
    logic unused_upd_lsb;
    assign unused_upd_lsb = ^update_pc[1:0];

    btb_entry_t      lk_ent       [WAYS];
    logic [WAYS-1:0] lk_hit_vec;
    logic [WAYS-1:0] up_match_vec;
    logic [WAYS-1:0] up_inv_vec;
    // Priority chains: element 0 ends up holding the lowest flagged way.
    logic [WAY_W-1:0] lk_enc    [WAYS+1];
    logic [WAY_W-1:0] match_enc [WAYS+1];
    logic [WAY_W-1:0] inv_enc   [WAYS+1];

    assign lk_enc[WAYS]    = '0;
    assign match_enc[WAYS] = '0;
    assign inv_enc[WAYS]   = '0;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign lk_ent[w] = '{vld:    vld_q[lk_idx][w],
                             tag:    32'(tag_mem[w][lk_idx]),
                             slot:   SLOT_W_MAX'(slot_mem[w][lk_idx]),
                             target: target_mem[w][lk_idx],
                             ctr:    ctr_q[w][lk_idx]};

        // A stored branch only redirects when it lies at or after the entry
        // slot and its counter predicts taken.
        assign lk_hit_vec[w] = lk_ent[w].vld
                            && (lk_ent[w].tag == 32'(lk_tag))
                            && (SLOT_W_MAX'(lk_slot) <= lk_ent[w].slot)
                            && (lk_ent[w].ctr >= CTR_WEAK_T);

        // Training matches on tag alone so weak entries can be retrained.
        assign up_match_vec[w] = vld_q[up_idx][w] && (tag_mem[w][up_idx] == up_tag);
        assign up_inv_vec[w]   = !vld_q[up_idx][w];

        assign lk_enc[w]    = lk_hit_vec[w]   ? WAY_W'(w) : lk_enc[w+1];
        assign match_enc[w] = up_match_vec[w] ? WAY_W'(w) : match_enc[w+1];
        assign inv_enc[w]   = up_inv_vec[w]   ? WAY_W'(w) : inv_enc[w+1];
    end

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic             way_hit;
    logic [WAY_W-1:0] hit_way;
    logic             bypass;
    logic [OFF-1:0]   hit_slot;

    assign way_hit = |lk_hit_vec;
    assign hit_way = lk_enc[0];
    assign bypass  = update_en && update_taken
                  && (up_tag == lk_tag) && (up_idx == lk_idx)
                  && (lk_slot <= up_slot);
    assign btb_hit = bypass || way_hit;

    // Select the redirect target and its slot; in-flight training wins.
    always_comb begin
        hit_slot  = '0;
        pc_target = '0;
        if (bypass) begin
            hit_slot  = up_slot;
            pc_target = update_target;
        end else if (way_hit) begin
            hit_slot  = OFF'(lk_ent[hit_way].slot);
            pc_target = lk_ent[hit_way].target;
        end
    end

    // Slots before the fetch entry point or past a taken branch are dead.
    for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
        assign inst_vld[i] = (OFF'(i) >= lk_slot) && (!btb_hit || (OFF'(i) <= hit_slot));
    end

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    logic             up_act;
    logic             up_match;
    logic             up_has_inv;
    logic [WAY_W-1:0] up_match_way;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W-1:0] up_way;
    logic             up_write;
    logic             up_data_we;
    logic [1:0]       up_ctr_nxt;

    assign up_act       = update_en && !flush;
    assign up_match     = |up_match_vec;
    assign up_has_inv   = |up_inv_vec;
    assign up_match_way = match_enc[0];
    assign up_way       = up_match   ? up_match_way :
                          up_has_inv ? inv_enc[0]   : vic_way;
    // A not-taken branch with no entry is not worth allocating.
    assign up_write     = up_act && (up_match || update_taken);
    assign up_data_we   = up_act && update_taken;
    assign up_ctr_nxt   = !up_match    ? CTR_WEAK_T :
                          update_taken ? ctr_inc(ctr_q[up_match_way][up_idx]) :
                                         ctr_dec(ctr_q[up_match_way][up_idx]);

    // Valid/counter state: reset clears, flush drops all entries, else train.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '{default: '0};
            ctr_q <= '{default: '0};
        end else if (flush) begin
            vld_q <= '{default: '0};
        end else if (up_write) begin
            vld_q[up_idx][up_way] <= 1'b1;
            ctr_q[up_way][up_idx] <= up_ctr_nxt;
        end
    end

    // Payload arrays: written on every taken training, never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && up_data_we) begin
            tag_mem[up_way][up_idx]    <= up_tag;
            slot_mem[up_way][up_idx]   <= up_slot;
            target_mem[up_way][up_idx] <= update_target;
        end
    end

    btb_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .lk_touch (way_hit && !stage1_hold),
        .lk_set   (lk_idx),
        .lk_way   (hit_way),
        .up_touch (up_write),
        .up_set   (up_idx),
        .up_way   (up_way),
        .vic_set  (up_idx),
        .vic_way  (vic_way)
    );

    // Registered next fetch address: redirect target or next sequential group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_target_stage1 <= '0;
        end else if (!stage1_hold) begin
            pc_target_stage1 <= btb_hit ? pc_target : (pc & ALIGN_MASK) + FETCH_BYTES;
        end
    end

endmodule
`default_nettype wire
